irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that sits between peripheral request lines (keyboard, screen, timers) and the mcu `interrupt`/`irq` inputs.
- Latches requests, applies per-source mask and edge/level mode, and picks the highest-priority source.
- Drives one interrupt to the mcu with a 3-bit vector, and holds it through an ack / end-of-interrupt handshake so only one interrupt is in service at a time.

Parameters:
- N_SRC, 8, number of request sources; the bench uses 2..8.
- VEC_W, 3, vector width; must satisfy 2**VEC_W >= N_SRC.
- DW, 16, register data width; matches the mcu word.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src  in  N_SRC  request lines, synchronous to clock.
- addr  in  2  register select.
- wr  in  1  register write strobe, one cycle.
- wdata  in  DW  write data.
- rdata  out  DW  read data, combinational from addr.
- interrupt  out  1  request to the mcu, registered.
- irq  out  VEC_W  vector index of the selected source, registered.
- int_ack  in  1  one-cycle pulse: the mcu has taken the vector.
- eoi  in  1  one-cycle pulse: the mcu executed IRET.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low (`reset_n`). Reset values: MASK=all 1s, EDGE=0, PEND=0, state=IDLE, sel=0, interrupt=0, irq=0. Asserting reset mid-operation aborts any REQ or SERVICE immediately.
- Register map:
  - 0 PEND: read pending bits. Write-1-clears edge-mode bits; level bits ignore writes.
  - 1 MASK: read/write. 1 = masked.
  - 2 EDGE: read/write. 1 = rising-edge source, 0 = level source.
  - 3 STAT: read-only = {busy (bit 15), state[1:0] (bits 9:8), sel (low VEC_W bits)}.
  - Unused high bits read 0.
- Edge sources:
  - The previous value of src is registered.
  - A rise sets PEND[i] on the next clock.
  - PEND[i] clears on a W1C write, or on int_ack while sel==i.
  - Set beats clear in the same cycle: a new edge is never lost.
- Level sources: PEND[i] = src[i] directly; nothing is latched.
- Active vector: act = PEND & ~MASK. Fixed priority, lowest index wins.
- State machine:
  - IDLE: if act != 0, go to REQ next cycle with sel = winner, interrupt=1, irq=winner. Latency from src rise to interrupt is 2 clocks for edge mode, 1 for level mode.
  - REQ: interrupt stays 1 and irq stays stable. If int_ack, go to SERVICE with interrupt=0 and clear edge PEND[sel]. Otherwise, if act[sel]==0 (withdrawn or masked), go to IDLE with interrupt=0. A higher-priority arrival does NOT preempt REQ.
  - SERVICE: interrupt=0, irq holds sel, busy=1. On eoi, go to IDLE. A new REQ can begin the cycle after that.
- Ignored inputs: eoi outside SERVICE; int_ack outside REQ.
- Simultaneous int_ack and eoi in REQ: the ack is taken and the eoi is ignored.
- A MASK write takes effect on the next cycle's act. It does not abort SERVICE.
- Sources at index >= N_SRC do not exist. Their register bits read 0 and ignore writes.

Decomposition:
- Package irq_ctrl_pkg:
  - register address constants REG_PEND=0, REG_MASK=1, REG_EDGE=2, REG_STAT=3;
  - state encoding IDLE=0, REQ=1, SERVICE=2.
- Sub-module irq_prio_enc: combinational N_SRC-bit fixed-priority encoder producing {valid, index}. Instantiated once.

Test Plan:
- Reset with MASK=FF, pulse src[2] in edge mode → PEND=04, interrupt stays 0. Write MASK=00 → interrupt=1 and irq=2 one cycle later.
- MASK=00, EDGE=FF, src[5] and src[1] rise in the same cycle → irq=1. int_ack → PEND=20. eoi → irq=5 two cycles after the eoi.
- Level source 3 asserted, then dropped while in REQ before any ack → interrupt falls next cycle, state IDLE, PEND=00.
- In SERVICE for source 0, assert src[0] edge again → PEND[0]=1, interrupt stays 0 until eoi, then re-asserts with irq=0.
- Edge rise on src[4] in the same cycle as a W1C write of 0x10 to PEND → PEND[4] reads 1 next cycle.
- Drop reset_n mid-SERVICE → interrupt=0, irq=0, STAT=0000, MASK=FF asynchronously, before the next clock edge.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared register map and FSM encoding for the interrupt controller.
// Pure declarations: no latency, no flow control.
package irq_ctrl_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, lowest index wins; purely combinational.
// Zero latency, no backpressure.
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int VEC_W = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [VEC_W-1:0] index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    // Scan downward so the last hit is the lowest set index.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches/masks requests, presents one vector to the mcu.
// interrupt rises 1 clock after a level request (2 for edge); the ack/eoi handshake gates new requests.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int VEC_W = 3,
  parameter int DW    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] src,
  input  logic [1:0]       addr,
  input  logic             wr,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic             interrupt,
  output logic [VEC_W-1:0] irq,
  input  logic             int_ack,
  input  logic             eoi
);

  state_t             state, state_n;
  logic [VEC_W-1:0]   sel, sel_n;
  logic               interrupt_n;
  logic [N_SRC-1:0]   mask, edge_mode, prev_src, edge_pend, edge_pend_n;
  logic [N_SRC-1:0]   pend, act, rise, clr, sel_oh;
  logic               ack_take, win_vld;
  logic [VEC_W-1:0]   win_idx;

  assign pend     = (edge_mode & edge_pend) | (~edge_mode & src);
  assign act      = pend & ~mask;
  assign rise     = src & ~prev_src;
  assign sel_oh   = N_SRC'(1) << sel;
  assign ack_take = (state == REQ) && int_ack;
  assign clr      = ((wr && addr == REG_PEND) ? wdata[N_SRC-1:0] : '0)
                  | (ack_take ? sel_oh : '0);
  // A rise in the same cycle as a clear wins so no edge is dropped.
  assign edge_pend_n = ((edge_pend & ~clr) | rise) & edge_mode;

  if (DW > N_SRC) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[DW-1:N_SRC];
  end

  irq_prio_enc #(.N_SRC(N_SRC), .VEC_W(VEC_W)) u_prio (
    .req   (act),
    .valid (win_vld),
    .index (win_idx)
  );

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    interrupt_n = (state == REQ);
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n     = REQ;
          sel_n       = win_idx;
          interrupt_n = 1'b1;
        end
      end
      REQ: begin
        if (ack_take) begin
          state_n     = SERVICE;
          interrupt_n = 1'b0;
        end else if ((act & sel_oh) == '0) begin
          state_n     = IDLE;
          interrupt_n = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi) state_n = IDLE;
      end
      default: begin
        state_n     = IDLE;
        interrupt_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel       <= '0;
      interrupt <= 1'b0;
      mask      <= '1;
      edge_mode <= '0;
      prev_src  <= '0;
      edge_pend <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      interrupt <= interrupt_n;
      prev_src  <= src;
      edge_pend <= edge_pend_n;
      if (wr && addr == REG_MASK) mask      <= wdata[N_SRC-1:0];
      if (wr && addr == REG_EDGE) edge_mode <= wdata[N_SRC-1:0];
    end
  end

  assign irq = sel;

  always_comb begin
    rdata = '0;
    case (addr)
      REG_PEND: rdata[N_SRC-1:0] = pend;
      REG_MASK: rdata[N_SRC-1:0] = mask;
      REG_EDGE: rdata[N_SRC-1:0] = edge_mode;
      REG_STAT: begin
        rdata[15]          = (state == SERVICE);
        rdata[9:8]         = state;
        rdata[VEC_W-1:0]   = sel;
      end
      default: rdata = '0;
    endcase
  end

endmodule
